// File: rtl/axis_inject_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axis_inject_arbiter
// Purpose  : Packet-level round-robin arbiter sharing one AXI-stream router
//            injection port among NUM_REQ local masters. A granted requester
//            keeps the port until its tlast beat is accepted, so packets never
//            interleave. The output side is a 2-entry skid buffer, which makes
//            every m_* output come straight from a register.
// Ports    : clk_noc, rst_n (async, active-low)
//            s_tvalid/s_tready/s_tdata/s_tlast/s_tid/s_tdest : per-requester
//            m_tvalid/m_tready/m_tdata/m_tlast/m_tid/m_tdest : to the router
//            grant_id : index of the locked (or last locked) requester
//            busy     : high while a packet is locked
// Revision : 1.0 - initial release
// ============================================================================
module axis_inject_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TDATA_WIDTH = 32,
    parameter int TID_WIDTH   = 2,
    parameter int TDEST_WIDTH = 2,
    parameter int GW          = $clog2(NUM_REQ)
) (
    input  logic                                clk_noc,
    input  logic                                rst_n,
    input  logic [NUM_REQ-1:0]                  s_tvalid,
    output logic [NUM_REQ-1:0]                  s_tready,
    input  logic [NUM_REQ-1:0][TDATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_REQ-1:0]                  s_tlast,
    input  logic [NUM_REQ-1:0][TID_WIDTH-1:0]   s_tid,
    input  logic [NUM_REQ-1:0][TDEST_WIDTH-1:0] s_tdest,
    output logic                                m_tvalid,
    input  logic                                m_tready,
    output logic [TDATA_WIDTH-1:0]              m_tdata,
    output logic                                m_tlast,
    output logic [TID_WIDTH-1:0]                m_tid,
    output logic [TDEST_WIDTH-1:0]              m_tdest,
    output logic [GW-1:0]                       grant_id,
    output logic                                busy
);

    // Skid entry layout: {last, tid, tdest, data}
    localparam int            C_EW       = TDATA_WIDTH + TID_WIDTH + TDEST_WIDTH + 1;
    localparam logic [GW:0]   C_NREQ     = (GW+1)'(NUM_REQ);
    localparam logic [GW-1:0] C_LAST_IDX = GW'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t            state_q;
    logic [GW-1:0]     rr_ptr_q;
    logic [GW-1:0]     grant_q;
    logic              busy_q;
    logic [1:0]        count_q, count_d;
    logic              full_q;
    logic              valid_q;
    logic [C_EW-1:0]   head_q, head_d;
    logic [C_EW-1:0]   tail_q, tail_d;

    logic [2*NUM_REQ-1:0] rot_dbl;
    logic [NUM_REQ-1:0]   rot;
    logic                 pick_found;
    logic [GW:0]          pick_off;
    logic [GW:0]          pick_sum;
    logic [GW-1:0]        pick_idx;
    logic                 accept;
    logic                 pop;
    logic [C_EW-1:0]      in_entry;

    // Rotate the request vector so bit 0 is the requester at rr_ptr; the
    // first set bit then gives the round-robin winner as an offset.
    assign rot_dbl = {s_tvalid, s_tvalid} >> rr_ptr_q;
    assign rot     = rot_dbl[NUM_REQ-1:0];

    always_comb begin
        pick_found = 1'b0;
        pick_off   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!pick_found && rot[k]) begin
                pick_found = 1'b1;
                pick_off   = (GW+1)'(k);
            end
        end
    end

    assign pick_sum = {1'b0, rr_ptr_q} + pick_off;
    assign pick_idx = (pick_sum >= C_NREQ) ? GW'(pick_sum - C_NREQ) : GW'(pick_sum);

    // Ready is decoded from registered state only, never from s_tvalid.
    always_comb begin
        s_tready = '0;
        if (state_q == ST_LOCKED && !full_q) begin
            s_tready[grant_q] = 1'b1;
        end
    end

    assign accept   = (state_q == ST_LOCKED) && s_tvalid[grant_q] && !full_q;
    assign pop      = valid_q && m_tready;
    assign in_entry = {s_tlast[grant_q], s_tid[grant_q], s_tdest[grant_q], s_tdata[grant_q]};

    // Two-entry skid FIFO: head drives m_*, tail only fills when head is stuck.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (count_q)
            2'd0: begin
                if (accept) begin
                    head_d  = in_entry;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (accept && pop) begin
                    head_d = in_entry;
                end else if (accept) begin
                    tail_d  = in_entry;
                    count_d = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            2'd2: begin
                // No push possible here: s_tready is low while full.
                if (pop) begin
                    head_d  = tail_q;
                    count_d = 2'd1;
                end
            end
            default: count_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            busy_q   <= 1'b0;
            count_q  <= 2'd0;
            full_q   <= 1'b0;
            valid_q  <= 1'b0;
            head_q   <= '0;
            tail_q   <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= (count_d != 2'd0);
            full_q  <= (count_d == 2'd2);
            case (state_q)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant_q <= pick_idx;
                        state_q <= ST_LOCKED;
                        busy_q  <= 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (accept && s_tlast[grant_q]) begin
                        state_q  <= ST_IDLE;
                        busy_q   <= 1'b0;
                        rr_ptr_q <= (grant_q == C_LAST_IDX) ? '0 : grant_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign m_tvalid = valid_q;
    assign m_tdata  = head_q[TDATA_WIDTH-1:0];
    assign m_tdest  = head_q[TDATA_WIDTH +: TDEST_WIDTH];
    assign m_tid    = head_q[TDATA_WIDTH+TDEST_WIDTH +: TID_WIDTH];
    assign m_tlast  = head_q[C_EW-1];
    assign grant_id = grant_q;
    assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_inject_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_inject_arbiter
// Purpose  : Self-checking bench for axis_inject_arbiter. Requester queues feed
//            the DUT; a packet-level round-robin model predicts the output
//            beat stream into a scoreboard that a monitor drains.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_inject_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 2;
    localparam int TW = 2;
    localparam int GW = 2;

    typedef struct packed {
        logic          last;
        logic [IW-1:0] tid;
        logic [TW-1:0] tdest;
        logic [DW-1:0] data;
    } beat_t;

    logic                 clk_noc = 1'b0;
    logic                 rst_n   = 1'b0;
    logic [N-1:0]         s_tvalid;
    logic [N-1:0]         s_tready;
    logic [N-1:0][DW-1:0] s_tdata;
    logic [N-1:0]         s_tlast;
    logic [N-1:0][IW-1:0] s_tid;
    logic [N-1:0][TW-1:0] s_tdest;
    logic                 m_tvalid;
    logic                 m_tready;
    logic [DW-1:0]        m_tdata;
    logic                 m_tlast;
    logic [IW-1:0]        m_tid;
    logic [TW-1:0]        m_tdest;
    logic [GW-1:0]        grant_id;
    logic                 busy;

    always #5 clk_noc = ~clk_noc;

    axis_inject_arbiter #(
        .NUM_REQ(N), .TDATA_WIDTH(DW), .TID_WIDTH(IW), .TDEST_WIDTH(TW)
    ) dut (
        .clk_noc(clk_noc), .rst_n(rst_n),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .s_tlast(s_tlast), .s_tid(s_tid), .s_tdest(s_tdest),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tlast(m_tlast), .m_tid(m_tid), .m_tdest(m_tdest),
        .grant_id(grant_id), .busy(busy)
    );

    beat_t drv_q [N][$];     // beats still to be offered by each requester
    beat_t mdl_q [N][$];     // same beats, not yet placed in the expected stream
    beat_t exp_q [$];        // expected output beats in order
    int    exp_grants [$];   // expected packet grant order
    int    model_ptr = 0;
    int    n_chk  = 0;
    int    n_pass = 0;
    int    gap_en   = 0;     // random tvalid gaps inside packets
    int    rdy_mode = 0;     // 0: m_tready=1, 1: random, 2: m_tready=0

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", nm, act, req);
    endtask

    task automatic push_beat(input int r, input logic [DW-1:0] d, input int tid,
                             input int tdest, input bit last);
        beat_t b;
        b.last  = last;
        b.tid   = IW'(tid);
        b.tdest = TW'(tdest);
        b.data  = d;
        drv_q[r].push_back(b);
        mdl_q[r].push_back(b);
    endtask

    task automatic add_rand_pkt(input int r, input int len);
        for (int i = 0; i < len; i++)
            push_beat(r, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), i == len - 1);
    endtask

    // Packet-level round robin: every requester holding queued packets is
    // visible at each arbitration; whole packets are emitted at a time.
    task automatic run_model();
        bit    any;
        int    g;
        beat_t b;
        do begin
            any = 0;
            g   = 0;
            for (int k = 0; k < N; k++) begin
                int r;
                r = (model_ptr + k) % N;
                if (!any && mdl_q[r].size() > 0) begin
                    any = 1;
                    g   = r;
                end
            end
            if (any) begin
                do begin
                    b = mdl_q[g].pop_front();
                    exp_q.push_back(b);
                end while (!b.last);
                exp_grants.push_back(g);
                model_ptr = (g + 1) % N;
            end
        end while (any);
    endtask

    task automatic tick();
        @(posedge clk_noc);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        int c;
        int pend;
        c = 0;
        pend = exp_q.size();
        for (int r = 0; r < N; r++) pend += drv_q[r].size();
        while ((pend != 0 || busy) && c < budget) begin
            tick();
            c++;
            pend = exp_q.size();
            for (int r = 0; r < N; r++) pend += drv_q[r].size();
        end
        chk("drain_pending", 64'(pend), 64'd0);
    endtask

    // Requester drivers: inputs change on the falling edge; a beat counts as
    // taken when valid and ready are both high ahead of the rising edge.
    initial begin
        bit    acc [N];
        bit    mid [N];
        beat_t b;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tlast  = '0;
        s_tid    = '0;
        s_tdest  = '0;
        for (int r = 0; r < N; r++) begin
            acc[r] = 0;
            mid[r] = 0;
        end
        forever begin
            @(negedge clk_noc);
            for (int r = 0; r < N; r++) begin
                if (!rst_n) mid[r] = 0;
                if (acc[r] && drv_q[r].size() > 0) begin
                    b = drv_q[r].pop_front();
                    mid[r] = !b.last;
                end
                if (drv_q[r].size() > 0 && !(gap_en != 0 && mid[r] && $urandom_range(0, 3) == 0)) begin
                    s_tvalid[r] = 1'b1;
                    s_tdata[r]  = drv_q[r][0].data;
                    s_tlast[r]  = drv_q[r][0].last;
                    s_tid[r]    = drv_q[r][0].tid;
                    s_tdest[r]  = drv_q[r][0].tdest;
                end else begin
                    s_tvalid[r] = 1'b0;
                    s_tdata[r]  = $urandom;
                    s_tlast[r]  = 1'($urandom_range(0, 1));
                end
                acc[r] = s_tvalid[r] && s_tready[r];
            end
        end
    end

    // Output monitor: drives m_tready, checks beats against the scoreboard and
    // checks that a stalled output holds still.
    initial begin
        bit         prev_stall;
        logic [37:0] cur, prv;
        beat_t      got, e;
        prev_stall = 0;
        prv        = '0;
        m_tready   = 1'b1;
        forever begin
            @(negedge clk_noc);
            if (!rst_n) begin
                prev_stall = 0;
            end else begin
                case (rdy_mode)
                    0:       m_tready = 1'b1;
                    1:       m_tready = ($urandom_range(0, 9) < 7);
                    default: m_tready = 1'b0;
                endcase
                cur = {m_tvalid, m_tlast, m_tid, m_tdest, m_tdata};
                if (prev_stall) chk("stall_stable", 64'(cur), 64'(prv));
                if (m_tvalid && m_tready) begin
                    got = {m_tlast, m_tid, m_tdest, m_tdata};
                    if (exp_q.size() == 0) begin
                        chk("spurious_beat", 64'(exp_q.size()), 64'd1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_beat", 64'(got), 64'(e));
                    end
                end
                prev_stall = m_tvalid && !m_tready;
                prv        = cur;
            end
        end
    end

    initial begin
        logic [DW-1:0] b0;
        int            ng;
        // Reset state
        repeat (2) @(posedge clk_noc);
        #1;
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_s_tready", 64'(s_tready), 64'd0);
        chk("rst_grant", 64'(grant_id), 64'd0);
        chk("rst_m_data", 64'({m_tlast, m_tid, m_tdest, m_tdata}), 64'd0);
        rst_n = 1'b1;
        tick();

        // Single 3-beat packet from req0: latency and busy window
        push_beat(0, 32'hA0, 2, 1, 0);
        push_beat(0, 32'hA1, 2, 1, 0);
        push_beat(0, 32'hA2, 2, 1, 1);
        run_model();
        tick();
        chk("t1_c1_busy", 64'(busy), 64'd1);
        chk("t1_c1_grant", 64'(grant_id), 64'd0);
        chk("t1_c1_mvalid", 64'(m_tvalid), 64'd0);
        tick();
        chk("t1_c2_out", 64'({m_tvalid, m_tlast, m_tid, m_tdest, m_tdata}), {27'd0, 1'b1, 1'b0, 2'd2, 2'd1, 32'hA0});
        chk("t1_c2_busy", 64'(busy), 64'd1);
        tick();
        chk("t1_c3_out", 64'({m_tvalid, m_tlast, m_tdata}), {30'd0, 1'b1, 1'b0, 32'hA1});
        chk("t1_c3_busy", 64'(busy), 64'd1);
        tick();
        chk("t1_c4_out", 64'({m_tvalid, m_tlast, m_tdata}), {30'd0, 1'b1, 1'b1, 32'hA2});
        chk("t1_c4_busy", 64'(busy), 64'd0);
        tick();
        chk("t1_c5_mvalid", 64'(m_tvalid), 64'd0);
        wait_drain(100);

        // Two requesters, continuous 2-beat packets
        for (int p = 0; p < 2; p++) begin
            add_rand_pkt(0, 2);
            add_rand_pkt(1, 2);
        end
        run_model();
        wait_drain(200);

        // Late requester waits for the locked packet to finish
        add_rand_pkt(0, 3);
        run_model();
        tick();
        chk("t3_grant0", 64'(grant_id), 64'd0);
        add_rand_pkt(2, 1);
        run_model();
        tick();
        chk("t3_rdy2_a", 64'(s_tready[2]), 64'd0);
        chk("t3_rdy0", 64'(s_tready[0]), 64'd1);
        tick();
        chk("t3_rdy2_b", 64'(s_tready[2]), 64'd0);
        tick();
        chk("t3_idle", 64'(busy), 64'd0);
        tick();
        chk("t3_grant2", 64'(grant_id), 64'd2);
        chk("t3_busy2", 64'(busy), 64'd1);
        chk("t3_rdy2_c", 64'(s_tready[2]), 64'd1);
        wait_drain(100);

        // Back-pressure: m_tready low for 5 cycles during a 4-beat packet
        rdy_mode = 2;
        b0 = 32'hC000_0000;
        for (int i = 0; i < 4; i++) push_beat(0, b0 + DW'(i), 1, 3, i == 3);
        run_model();
        tick();
        tick();
        chk("t4_rdy_1buf", 64'(s_tready[0]), 64'd1);
        tick();
        chk("t4_rdy_full", 64'(s_tready[0]), 64'd0);
        chk("t4_head", 64'({m_tvalid, m_tdata}), {31'd0, 1'b1, b0});
        tick();
        chk("t4_rdy_full2", 64'(s_tready[0]), 64'd0);
        tick();
        chk("t4_head2", 64'({m_tvalid, m_tdata}), {31'd0, 1'b1, b0});
        rdy_mode = 0;
        wait_drain(100);

        // Reset mid-packet
        add_rand_pkt(3, 4);
        run_model();
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("t6_mvalid", 64'(m_tvalid), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_s_tready", 64'(s_tready), 64'd0);
        exp_q.delete();
        exp_grants.delete();
        for (int r = 0; r < N; r++) begin
            drv_q[r].delete();
            mdl_q[r].delete();
        end
        model_ptr = 0;
        tick();
        rst_n = 1'b1;
        tick();
        add_rand_pkt(3, 2);
        add_rand_pkt(1, 2);
        run_model();
        tick();
        chk("t6_fresh_grant", 64'(grant_id), 64'(exp_grants[0]));
        wait_drain(100);

        // Single-beat packets from every requester, req0 twice
        exp_grants.delete();
        for (int r = 0; r < N; r++) push_beat(r, DW'(r), r % 4, 0, 1);
        push_beat(0, 32'h100, 0, 0, 1);
        run_model();
        ng = exp_grants.size();
        for (int k = 0; k < ng; k++) begin
            tick();
            chk("t5_grant", 64'(grant_id), 64'(exp_grants[k]));
            chk("t5_busy", 64'(busy), 64'd1);
            tick();
            chk("t5_bubble", 64'(busy), 64'd0);
        end
        wait_drain(100);

        // Randomized traffic with gaps and back-pressure
        rdy_mode = 1;
        gap_en   = 1;
        for (int round = 0; round < 30; round++) begin
            for (int r = 0; r < N; r++)
                if ($urandom_range(0, 1) == 1)
                    for (int p = 0; p < int'($urandom_range(1, 3)); p++)
                        add_rand_pkt(r, $urandom_range(1, 5));
            run_model();
            wait_drain(2000);
        end
        rdy_mode = 0;
        gap_en   = 0;
        tick();
        chk("final_exp_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
